// File: rtl/fifo_stream_arbiter_if.sv
// Bundles the producer, FIFO and consumer signals around the shared-FIFO arbiter.
// master is the arbiter side; slave is the environment side.
interface fifo_stream_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IDX_WIDTH  = 2
);
    logic [NUM_REQ-1:0]            req_Valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_Data;
    logic [NUM_REQ-1:0]            req_Ready;
    logic [IDX_WIDTH-1:0]          grant_Index;
    logic                          write_Enable;
    logic [DATA_WIDTH-1:0]         buffer_Input;
    logic                          sig_Full;
    logic                          read_Enable;
    logic [DATA_WIDTH-1:0]         buffer_Output;
    logic                          sig_Empty;
    logic                          out_Valid;
    logic [DATA_WIDTH-1:0]         out_Data;
    logic                          out_Ready;

    modport master (
        input  req_Valid, req_Data, sig_Full, buffer_Output, sig_Empty, out_Ready,
        output req_Ready, grant_Index, write_Enable, buffer_Input, read_Enable,
        output out_Valid, out_Data
    );

    modport slave (
        output req_Valid, req_Data, sig_Full, buffer_Output, sig_Empty, out_Ready,
        input  req_Ready, grant_Index, write_Enable, buffer_Input, read_Enable,
        input  out_Valid, out_Data
    );
endinterface

// File: rtl/fifo_stream_arbiter.sv
// Round-robin write arbiter feeding a shared FIFO, plus a read sequencer that
// turns FIFO reads into a registered valid/ready stream for one consumer.
module fifo_stream_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IDX_WIDTH  = 2
) (
    input logic                  clock,
    input logic                  reset,
    fifo_stream_arbiter_if.master bus
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

    logic [IDX_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_WIDTH-1:0]  winner;
    logic                  found;
    logic                  grant_en;
    int unsigned           scan_idx;

    state_e                state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  read_en;

    // Scan requesters starting at rr_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && |(bus.req_Valid & (NUM_REQ'(1) << scan_idx))) begin
                found  = 1'b1;
                winner = IDX_WIDTH'(scan_idx);
            end
        end
    end

    assign grant_en = found && !bus.sig_Full && reset;

    always_comb begin
        bus.req_Ready    = '0;
        bus.grant_Index  = '0;
        bus.write_Enable = 1'b0;
        bus.buffer_Input = '0;
        rr_ptr_d         = rr_ptr_q;
        if (grant_en) begin
            bus.req_Ready    = NUM_REQ'(1) << winner;
            bus.grant_Index  = winner;
            bus.write_Enable = 1'b1;
            bus.buffer_Input = DATA_WIDTH'(bus.req_Data >> (32'(winner) * DATA_WIDTH));
            rr_ptr_d         = (32'(winner) == NUM_REQ - 1) ? '0 : winner + IDX_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Read sequencer: one word per two cycles, data captured the cycle after the read.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        read_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                out_valid_d = 1'b0;
                if (!bus.sig_Empty) begin
                    read_en = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                out_data_d  = bus.buffer_Output;
                out_valid_d = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (bus.out_Ready) begin
                    out_valid_d = 1'b0;
                    if (!bus.sig_Empty) begin
                        read_en = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.read_Enable = read_en && reset;
    assign bus.out_Valid   = out_valid_q;
    assign bus.out_Data    = out_data_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_fifo_stream_arbiter.sv
// Directed bench for fifo_stream_arbiter: arbitration order, full gating,
// read sequencing, backpressure and reset during an in-flight fetch.
module tb_fifo_stream_arbiter;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    fifo_stream_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8), .IDX_WIDTH(2)) bus ();

    fifo_stream_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .IDX_WIDTH(2)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Small FIFO stand-in; tb_* values are used when model_sel is low.
    logic       model_sel;
    logic       tb_empty;
    logic [7:0] tb_bufout;
    logic [7:0] mdata [4];
    int         mcount;
    int         mrd;
    logic [7:0] model_out;

    assign bus.sig_Empty     = model_sel ? (mrd >= mcount) : tb_empty;
    assign bus.buffer_Output = model_sel ? model_out : tb_bufout;

    always @(posedge clock) begin
        if (!reset) begin
            mrd <= 0;
        end else if (model_sel && bus.read_Enable && mrd < 4) begin
            model_out <= mdata[mrd];
            mrd       <= mrd + 1;
        end
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.req_Valid = 4'hF;
        bus.req_Data  = {8'h40, 8'h30, 8'h20, 8'h10};
        bus.sig_Full  = 1'b0;
        bus.out_Ready = 1'b0;
        tb_empty      = 1'b0;
        tb_bufout     = 8'h00;
        tick();
        tick();
        #1;
        checks++;
        if (bus.req_Ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_req_ready got %b want 0000", bus.req_Ready);
        end
        checks++;
        if (bus.write_Enable !== 1'b0 || bus.read_Enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_enables got we=%b re=%b want 0 0",
                     bus.write_Enable, bus.read_Enable);
        end
        checks++;
        if (bus.grant_Index !== 2'd0 || bus.buffer_Input !== 8'h00) begin
            errors++;
            $display("FAIL reset_grant got idx=%0d bi=%h want 0 00",
                     bus.grant_Index, bus.buffer_Input);
        end
        checks++;
        if (bus.out_Valid !== 1'b0 || bus.out_Data !== 8'h00) begin
            errors++;
            $display("FAIL reset_out got v=%b d=%h want 0 00", bus.out_Valid, bus.out_Data);
        end
        tb_empty = 1'b1;
        reset    = 1'b1;
        #1;
        checks++;
        if (bus.req_Ready !== 4'b0001 || bus.grant_Index !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_grant got rdy=%b idx=%0d want 0001 0",
                     bus.req_Ready, bus.grant_Index);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_idx;
        for (int i = 0; i < 8; i++) begin
            exp_idx = 2'(i % 4);
            checks++;
            if (bus.grant_Index !== exp_idx || bus.req_Ready !== (4'b0001 << exp_idx) ||
                bus.write_Enable !== 1'b1 ||
                bus.buffer_Input !== 8'((32'(exp_idx) + 1) * 16)) begin
                errors++;
                $display("FAIL rr_grant_%0d got idx=%0d rdy=%b we=%b bi=%h want idx=%0d",
                         i, bus.grant_Index, bus.req_Ready, bus.write_Enable,
                         bus.buffer_Input, exp_idx);
            end
            tick();
        end
    endtask

    task automatic test_full();
        bus.sig_Full  = 1'b1;
        bus.req_Valid = 4'b1010;
        #1;
        checks++;
        if (bus.req_Ready !== 4'b0000 || bus.write_Enable !== 1'b0) begin
            errors++;
            $display("FAIL full_block got rdy=%b we=%b want 0000 0",
                     bus.req_Ready, bus.write_Enable);
        end
        tick();
        tick();
        bus.sig_Full = 1'b0;
        #1;
        checks++;
        if (bus.grant_Index !== 2'd1 || bus.req_Ready !== 4'b0010 ||
            bus.buffer_Input !== 8'h20) begin
            errors++;
            $display("FAIL full_release_ptr0 got idx=%0d rdy=%b bi=%h want 1 0010 20",
                     bus.grant_Index, bus.req_Ready, bus.buffer_Input);
        end
        tick();
        bus.sig_Full = 1'b1;
        #1;
        checks++;
        if (bus.write_Enable !== 1'b0 || bus.grant_Index !== 2'd0) begin
            errors++;
            $display("FAIL full_block2 got we=%b idx=%0d want 0 0",
                     bus.write_Enable, bus.grant_Index);
        end
        tick();
        bus.sig_Full = 1'b0;
        #1;
        checks++;
        if (bus.grant_Index !== 2'd3 || bus.req_Ready !== 4'b1000 ||
            bus.buffer_Input !== 8'h40) begin
            errors++;
            $display("FAIL full_release_ptr2 got idx=%0d rdy=%b bi=%h want 3 1000 40",
                     bus.grant_Index, bus.req_Ready, bus.buffer_Input);
        end
        bus.req_Valid = 4'b0000;
        tick();
    endtask

    task automatic test_read_sequence();
        logic [7:0] exp_re;
        logic [7:0] exp_ov;
        reset     = 1'b0;
        model_sel = 1'b1;
        mdata[0]  = 8'hA1;
        mdata[1]  = 8'hA2;
        mdata[2]  = 8'hA3;
        mdata[3]  = 8'h00;
        mcount    = 3;
        bus.out_Ready = 1'b1;
        tick();
        reset  = 1'b1;
        exp_re = 8'b0001_0101;
        exp_ov = 8'b0101_0100;
        #1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.read_Enable !== exp_re[i] || bus.out_Valid !== exp_ov[i]) begin
                errors++;
                $display("FAIL seq_cycle_%0d got re=%b ov=%b want re=%b ov=%b",
                         i, bus.read_Enable, bus.out_Valid, exp_re[i], exp_ov[i]);
            end
            if (exp_ov[i]) begin
                checks++;
                if (bus.out_Data !== 8'(8'hA0 + i / 2)) begin
                    errors++;
                    $display("FAIL seq_data_%0d got %h want %h", i, bus.out_Data,
                             8'(8'hA0 + i / 2));
                end
            end
            checks++;
            if (bus.read_Enable && bus.sig_Empty) begin
                errors++;
                $display("FAIL seq_read_empty_%0d got re=1 empty=1 want no read", i);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        reset     = 1'b0;
        model_sel = 1'b1;
        mdata[0]  = 8'h5C;
        mdata[1]  = 8'h6D;
        mcount    = 2;
        bus.out_Ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_Valid !== 1'b1 || bus.out_Data !== 8'h5C ||
                bus.read_Enable !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d got ov=%b d=%h re=%b want 1 5c 0",
                         i, bus.out_Valid, bus.out_Data, bus.read_Enable);
            end
            tick();
        end
        bus.out_Ready = 1'b1;
        #1;
        checks++;
        if (bus.read_Enable !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_read got %b want 1", bus.read_Enable);
        end
        tick();
        checks++;
        if (bus.out_Valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_valid_drop got %b want 0", bus.out_Valid);
        end
        tick();
        checks++;
        if (bus.out_Valid !== 1'b1 || bus.out_Data !== 8'h6D) begin
            errors++;
            $display("FAIL bp_next_word got ov=%b d=%h want 1 6d", bus.out_Valid, bus.out_Data);
        end
        tick();
    endtask

    task automatic test_reset_in_fetch();
        reset     = 1'b0;
        model_sel = 1'b0;
        tb_empty  = 1'b0;
        tb_bufout = 8'h77;
        bus.out_Ready = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (bus.read_Enable !== 1'b1) begin
            errors++;
            $display("FAIL rf_read_issue got %b want 1", bus.read_Enable);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.read_Enable !== 1'b0) begin
            errors++;
            $display("FAIL rf_read_gated got %b want 0", bus.read_Enable);
        end
        tick();
        checks++;
        if (bus.out_Valid !== 1'b0 || bus.out_Data !== 8'h00) begin
            errors++;
            $display("FAIL rf_discard got ov=%b d=%h want 0 00", bus.out_Valid, bus.out_Data);
        end
        tb_empty = 1'b1;
        reset    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.out_Valid !== 1'b0 || bus.out_Data === 8'h77) begin
                errors++;
                $display("FAIL rf_no_leak_%0d got ov=%b d=%h want 0 not-77",
                         i, bus.out_Valid, bus.out_Data);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        model_sel = 1'b0;
        mcount    = 0;
        for (int i = 0; i < 4; i++) mdata[i] = 8'h00;
        test_reset();
        test_round_robin();
        test_full();
        test_read_sequence();
        test_backpressure();
        test_reset_in_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
